tt_um_jleugeri_ttt_scheduler: RTL and testbench
===============================================

TT_UM_JLEUGERI_TTT_SCHEDULER -- requirements
Module: tt_um_jleugeri_ttt_scheduler

Interface
REQ-001 SHALL have parameters: NUM_PROCESSORS, 10, processor count; TOKENS_BITS, 8, token word width; PROG_HEADER, 4, header width; PROG_BITS, 8, program data width; DIV_BITS, 8, tick divider width; EVT_DEPTH, 4, event FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports, clock and reset first; PID_W = $clog2(NUM_PROCESSORS):
- clock_fast  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- mode  in  2  00 idle, 01 program, 10 run, 11 single-step
- tick_div  in  DIV_BITS  fast cycles per tick; 0 treated as 1
- prog_valid / prog_ready  in / out  1  program-word handshake
- prog_header_in / prog_data_in  in  PROG_HEADER / PROG_BITS  program word
- prog_strobe  out  1  one-cycle word-valid pulse to core
- prog_header / prog_data  out  PROG_HEADER / PROG_BITS  registered program word
- inj_we  in  1  token injection write
- inj_id  in  PID_W  target processor
- inj_tokens  in  TOKENS_BITS  tokens to add
- clock_slow  out  1  one-cycle tick pulse to core
- hold  out  1  core freeze; high except in SCAN
- done  in  1  core finished tick processing
- processor_id  out  PID_W  processor being scanned
- tokens_in  out  TOKENS_BITS  pending tokens for processor_id
- token_startstop  in  2  core event code for processor_id
- evt_valid / evt_ready  out / in  1  event output handshake
- evt_id / evt_code  out  PID_W / 2  head event
- overflow  out  1  sticky event-drop flag

Function
REQ-003 SHALL implement states IDLE, PROG, WAIT_DIV, WAIT_DONE, SCAN.
REQ-004 IDLE: mode 01 -> PROG, mode 10 or 11 -> WAIT_DIV with divider loaded to max(tick_div,1); transition on the next edge.
REQ-005 PROG: prog_ready=1 when mode==01 and prog_strobe==0; accepted word (valid&ready) registered, prog_strobe=1 next cycle, so max one word per 2 cycles; mode!=01 -> IDLE after any pending strobe.
REQ-006 WAIT_DIV: decrement divider each cycle; on reaching 1, clock_slow=1 for exactly one cycle, go WAIT_DONE; mode 00 or 01 here -> IDLE immediately, no tick issued.
REQ-007 WAIT_DONE: hold=1; first cycle with done=1 -> SCAN with processor_id=0.
REQ-008 SCAN: hold=0, processor_id increments by 1 per cycle 0..NUM_PROCESSORS-1, no gaps; tokens_in = pending[processor_id] combinationally; pending[processor_id] cleared at end of that cycle.
REQ-009 SCAN exit after processor NUM_PROCESSORS-1: mode 10 -> WAIT_DIV (divider reloaded); mode 11 -> IDLE; other -> IDLE. Mode changes never abort a scan.
REQ-010 Injection: inj_we adds inj_tokens to pending[inj_id], saturating at 2^TOKENS_BITS-1; accepted in every state; inj_id >= NUM_PROCESSORS ignored.
REQ-011 Injection to the processor being scanned in that same cycle SHALL land in pending after the clear (not lost, not presented this tick).
REQ-012 Event capture: each SCAN cycle with token_startstop!=00 pushes {processor_id, token_startstop} into EVT_DEPTH-entry FIFO.
REQ-013 FIFO full on push with no same-cycle pop: event dropped, overflow set; simultaneous push and pop when full SHALL succeed without drop.
REQ-014 evt_valid = FIFO non-empty; evt_id/evt_code show head; pop on evt_valid&evt_ready; data stable while valid and not ready.
REQ-015 overflow sticky until reset; clock_slow and prog_strobe never asserted in the same cycle.

Reset
REQ-016 reset SHALL asynchronously force IDLE, hold=1, clock_slow=0, prog_strobe=0, prog_ready=0, prog_header/prog_data=0, processor_id=0, pending all 0, FIFO empty, evt_valid=0, overflow=0, divider=0.
REQ-017 Reset mid-SCAN or mid-PROG SHALL discard all in-flight words, tokens and events; first tick after release needs a full divider period.

Verification
REQ-018 Run timing: mode=10, tick_div=3, done tied 1 -> clock_slow pulses every 3+1+10=14 cycles, processor_id 0..9 in consecutive cycles.
REQ-019 Injection: inj 200 then 100 to id 4 before tick -> tokens_in=255 when processor_id=4, 0 on next tick; inj_id=12 -> no effect.
REQ-020 Events: token_startstop=01 at ids 2,5,7, evt_ready=0, EVT_DEPTH=4 -> 3 events queued in order; 2 more at next tick -> 4th stored, 5th dropped, overflow=1.
REQ-021 Program: prog_valid held 1 with 3 words -> 3 prog_strobe pulses on alternate cycles, words in order; mode->00 mid-run in SCAN -> scan finishes, then IDLE.
REQ-022 Step/reset: mode=11 -> exactly one tick then IDLE; reset asserted at processor_id=5 -> all outputs at reset values same cycle, FIFO empty.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_scheduler_if.sv
// Bundle of the scheduler's mode/program/injection/core/event signals.
// The slave side is the scheduler; the master side is whatever drives it.
interface tt_um_jleugeri_ttt_scheduler_if #(
  parameter int NUM_PROCESSORS = 10,
  parameter int TOKENS_BITS    = 8,
  parameter int PROG_HEADER    = 4,
  parameter int PROG_BITS      = 8,
  parameter int DIV_BITS       = 8
);
  localparam int PID_W = $clog2(NUM_PROCESSORS);

  logic [1:0]             mode;
  logic [DIV_BITS-1:0]    tick_div;
  logic                   prog_valid;
  logic                   prog_ready;
  logic [PROG_HEADER-1:0] prog_header_in;
  logic [PROG_BITS-1:0]   prog_data_in;
  logic                   prog_strobe;
  logic [PROG_HEADER-1:0] prog_header;
  logic [PROG_BITS-1:0]   prog_data;
  logic                   inj_we;
  logic [PID_W-1:0]       inj_id;
  logic [TOKENS_BITS-1:0] inj_tokens;
  logic                   clock_slow;
  logic                   hold;
  logic                   done;
  logic [PID_W-1:0]       processor_id;
  logic [TOKENS_BITS-1:0] tokens_in;
  logic [1:0]             token_startstop;
  logic                   evt_valid;
  logic                   evt_ready;
  logic [PID_W-1:0]       evt_id;
  logic [1:0]             evt_code;
  logic                   overflow;

  modport slave (
    input  mode, tick_div, prog_valid, prog_header_in, prog_data_in,
           inj_we, inj_id, inj_tokens, done, token_startstop, evt_ready,
    output prog_ready, prog_strobe, prog_header, prog_data, clock_slow, hold,
           processor_id, tokens_in, evt_valid, evt_id, evt_code, overflow
  );

  modport master (
    output mode, tick_div, prog_valid, prog_header_in, prog_data_in,
           inj_we, inj_id, inj_tokens, done, token_startstop, evt_ready,
    input  prog_ready, prog_strobe, prog_header, prog_data, clock_slow, hold,
           processor_id, tokens_in, evt_valid, evt_id, evt_code, overflow
  );
endinterface

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Tick scheduler: divides the fast clock into core ticks, scans every processor once
// per tick handing it its pending tokens, and queues the start/stop events it reports.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int TOKENS_BITS    = 8,
  parameter int PROG_HEADER    = 4,
  parameter int PROG_BITS      = 8,
  parameter int DIV_BITS       = 8,
  parameter int EVT_DEPTH      = 4
) (
  input  logic clock_fast,
  input  logic reset,
  tt_um_jleugeri_ttt_scheduler_if.slave bus
);
  localparam int PID_W = $clog2(NUM_PROCESSORS);
  localparam int PTR_W = $clog2(EVT_DEPTH);
  localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PROCESSORS - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(EVT_DEPTH);
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PROG = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [2:0] {IDLE, PROG, WAIT_DIV, WAIT_DONE, SCAN} state_t;

  state_t                 state;
  logic [DIV_BITS-1:0]    divider;
  logic                   stepped;
  logic                   clock_slow;
  logic                   prog_strobe;
  logic [PROG_HEADER-1:0] prog_header;
  logic [PROG_BITS-1:0]   prog_data;
  logic [PID_W-1:0]       processor_id;
  logic                   prog_ready;
  logic                   prog_accept;

  logic [TOKENS_BITS-1:0] pending     [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0] pending_nxt [NUM_PROCESSORS];

  logic [PID_W+1:0]       fifo_mem [EVT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   overflow;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   push_ok;

  function automatic logic [TOKENS_BITS-1:0] sat_add(input logic [TOKENS_BITS-1:0] a,
                                                     input logic [TOKENS_BITS-1:0] b);
    logic [TOKENS_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[TOKENS_BITS] ? '1 : sum[TOKENS_BITS-1:0];
  endfunction

  function automatic logic [DIV_BITS-1:0] div_load(input logic [DIV_BITS-1:0] d);
    return (d == '0) ? DIV_BITS'(1) : d;
  endfunction

  assign prog_ready  = (state == PROG) && (bus.mode == MODE_PROG) && !prog_strobe;
  assign prog_accept = bus.prog_valid && prog_ready;

  // A finished single step is remembered until mode leaves 11, so a held step
  // request produces exactly one tick.
  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      divider      <= '0;
      stepped      <= 1'b0;
      clock_slow   <= 1'b0;
      prog_strobe  <= 1'b0;
      prog_header  <= '0;
      prog_data    <= '0;
      processor_id <= '0;
    end else begin
      clock_slow  <= 1'b0;
      prog_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mode != MODE_STEP) stepped <= 1'b0;
          if (bus.mode == MODE_PROG) begin
            state <= PROG;
          end else if (bus.mode == MODE_RUN || (bus.mode == MODE_STEP && !stepped)) begin
            state   <= WAIT_DIV;
            divider <= div_load(bus.tick_div);
          end
        end
        PROG: begin
          if (prog_accept) begin
            prog_strobe <= 1'b1;
            prog_header <= bus.prog_header_in;
            prog_data   <= bus.prog_data_in;
          end
          if (bus.mode != MODE_PROG) state <= IDLE;
        end
        WAIT_DIV: begin
          if (bus.mode == MODE_IDLE || bus.mode == MODE_PROG) begin
            state <= IDLE;
          end else if (divider <= DIV_BITS'(1)) begin
            clock_slow <= 1'b1;
            state      <= WAIT_DONE;
          end else begin
            divider <= divider - DIV_BITS'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            state        <= SCAN;
            processor_id <= '0;
          end
        end
        SCAN: begin
          if (processor_id == LAST_PID) begin
            processor_id <= '0;
            if (bus.mode == MODE_RUN) begin
              state   <= WAIT_DIV;
              divider <= div_load(bus.tick_div);
            end else begin
              state   <= IDLE;
              stepped <= (bus.mode == MODE_STEP);
            end
          end else begin
            processor_id <= processor_id + PID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The scan clear is applied first so a same-cycle injection survives into the next tick.
  always_comb begin
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      pending_nxt[i] = pending[i];
      if (state == SCAN && processor_id == PID_W'(i)) pending_nxt[i] = '0;
      if (bus.inj_we && bus.inj_id == PID_W'(i))
        pending_nxt[i] = sat_add(pending_nxt[i], bus.inj_tokens);
    end
  end

  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PROCESSORS; i++) pending[i] <= pending_nxt[i];
    end
  end

  assign push    = (state == SCAN) && (bus.token_startstop != 2'b00);
  assign pop     = (count != '0) && bus.evt_ready;
  assign full    = (count == FULL_CNT);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock_fast) begin
    if (push_ok) fifo_mem[wr_ptr] <= {processor_id, bus.token_startstop};
  end

  assign bus.prog_ready   = prog_ready;
  assign bus.prog_strobe  = prog_strobe;
  assign bus.prog_header  = prog_header;
  assign bus.prog_data    = prog_data;
  assign bus.clock_slow   = clock_slow;
  assign bus.hold         = (state != SCAN);
  assign bus.processor_id = processor_id;
  assign bus.tokens_in    = pending[processor_id];
  assign bus.evt_valid    = (count != '0);
  assign bus.evt_id       = fifo_mem[rd_ptr][PID_W+1:2];
  assign bus.evt_code     = fifo_mem[rd_ptr][1:0];
  assign bus.overflow     = overflow;
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Directed bench for the tick scheduler: injection table plus run, program, event and reset sequences.
module tb_tt_um_jleugeri_ttt_scheduler;
  localparam int NP = 10;
  localparam int TB = 8;
  localparam int PH = 4;
  localparam int PB = 8;
  localparam int DB = 8;
  localparam int ED = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_um_jleugeri_ttt_scheduler_if #(.NUM_PROCESSORS(NP), .TOKENS_BITS(TB), .PROG_HEADER(PH),
                                    .PROG_BITS(PB), .DIV_BITS(DB)) bus ();

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(NP), .TOKENS_BITS(TB), .PROG_HEADER(PH),
                                 .PROG_BITS(PB), .DIV_BITS(DB), .EVT_DEPTH(ED)) dut (
    .clock_fast(clk),
    .reset(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tok [NP];
  bit         chk_tok;
  logic [9:0] ev_mask;
  logic [1:0] ev_code;
  logic [9:0] rdy_mask;
  bit         inj_en;
  int         inj_pid;
  logic [7:0] inj_amt;

  typedef struct {
    logic [3:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic [7:0] div;
    int         lat;
  } inj_vec_t;
  inj_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic inject(input logic [3:0] id, input logic [7:0] amt);
    bus.inj_we = 1'b1; bus.inj_id = id; bus.inj_tokens = amt;
    @(negedge clk);
    bus.inj_we = 1'b0;
  endtask

  // One single-step tick; exp_lat>0 also checks cycles from mode=11 to clock_slow.
  task automatic do_tick(input int exp_lat);
    int lat;
    bit seen;
    bus.mode = 2'b11;
    lat = 0; seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (bus.clock_slow) seen = 1;
    end
    check("tick_seen", seen, 1);
    if (exp_lat > 0) check("tick_latency", lat, exp_lat);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (!bus.hold) seen = 1;
      else @(negedge clk);
    end
    check("scan_start", seen, 1);
    for (int p = 0; p < NP; p++) begin
      check("scan_pid", bus.processor_id, p);
      check("scan_hold", bus.hold, 0);
      if (chk_tok) check("tokens_in", bus.tokens_in, exp_tok[p]);
      bus.token_startstop = ev_mask[p] ? ev_code : 2'b00;
      bus.evt_ready = rdy_mask[p];
      bus.inj_we = inj_en && (inj_pid == p);
      bus.inj_id = inj_pid[3:0];
      bus.inj_tokens = inj_amt;
      @(negedge clk);
    end
    bus.token_startstop = 2'b00; bus.evt_ready = 1'b0; bus.inj_we = 1'b0;
    check("post_scan_hold", bus.hold, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.clock_slow) seen = 1;
    end
    check("single_step_once", seen, 0);
    bus.mode = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int pulse [3];
    int npulse, cyc, idx, ns, last;
    bit hs, seen;
    logic [3:0] wh [3];
    logic [7:0] wd [3];

    rst = 1'b1;
    bus.mode = 2'b00; bus.tick_div = 8'd3; bus.prog_valid = 1'b0;
    bus.prog_header_in = '0; bus.prog_data_in = '0;
    bus.inj_we = 1'b0; bus.inj_id = '0; bus.inj_tokens = '0;
    bus.done = 1'b1; bus.token_startstop = 2'b00; bus.evt_ready = 1'b0;
    chk_tok = 0; ev_mask = '0; ev_code = 2'b00; rdy_mask = '0;
    inj_en = 0; inj_pid = 0; inj_amt = '0;
    #1;
    check("rst_hold", bus.hold, 1);
    check("rst_clock_slow", bus.clock_slow, 0);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_pid", bus.processor_id, 0);
    check("rst_prog_ready", bus.prog_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Injection table: two adds to one id, then a single-step tick shows the sum.
    vecs[0] = '{4'd4,  8'd200, 8'd100, 8'd255, 8'd3, 4};
    vecs[1] = '{4'd4,  8'd0,   8'd0,   8'd0,   8'd0, 2};
    vecs[2] = '{4'd0,  8'd1,   8'd2,   8'd3,   8'd1, 2};
    vecs[3] = '{4'd9,  8'd128, 8'd127, 8'd255, 8'd3, 4};
    vecs[4] = '{4'd12, 8'd50,  8'd60,  8'd0,   8'd3, 4};
    vecs[5] = '{4'd7,  8'd255, 8'd1,   8'd255, 8'd3, 4};
    vecs[6] = '{4'd9,  8'd100, 8'd27,  8'd127, 8'd3, 4};
    vecs[7] = '{4'd3,  8'd20,  8'd0,   8'd20,  8'd3, 4};
    chk_tok = 1;
    for (int v = 0; v < 8; v++) begin
      inject(vecs[v].id, vecs[v].a);
      inject(vecs[v].id, vecs[v].b);
      for (int p = 0; p < NP; p++) exp_tok[p] = (p == int'(vecs[v].id)) ? vecs[v].exp : 8'd0;
      bus.tick_div = vecs[v].div;
      do_tick(vecs[v].lat);
    end
    bus.tick_div = 8'd3;

    // Same-cycle injection while processor 3 is scanned: refill of 20, then 50 next tick.
    inject(4'd3, 8'd20);
    inj_en = 1; inj_pid = 3; inj_amt = 8'd50;
    for (int p = 0; p < NP; p++) exp_tok[p] = (p == 3) ? 8'd20 : 8'd0;
    do_tick(4);
    inj_en = 0;
    for (int p = 0; p < NP; p++) exp_tok[p] = (p == 3) ? 8'd50 : 8'd0;
    do_tick(4);
    chk_tok = 0;

    // Free-running ticks every 14 cycles; mode drops to 00 mid-scan.
    bus.mode = 2'b10;
    npulse = 0; cyc = 0;
    for (int c = 0; c < 300 && npulse < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.clock_slow) begin pulse[npulse] = cyc; npulse++; end
    end
    check("run_pulses", npulse, 3);
    check("run_first", pulse[0], 4);
    check("run_period_a", pulse[1] - pulse[0], 14);
    check("run_period_b", pulse[2] - pulse[1], 14);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (!bus.hold) seen = 1; else @(negedge clk);
    end
    check("run_scan_start", seen, 1);
    for (int p = 0; p < NP; p++) begin
      check("run_pid", bus.processor_id, p);
      if (p == 3) bus.mode = 2'b00;
      @(negedge clk);
    end
    check("abort_idle_hold", bus.hold, 1);
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.clock_slow) seen = 1; end
    check("abort_no_tick", seen, 0);

    // Program words with valid held high.
    wh[0] = 4'hA; wd[0] = 8'h11;
    wh[1] = 4'h5; wd[1] = 8'h22;
    wh[2] = 4'hF; wd[2] = 8'hC3;
    bus.prog_header_in = wh[0]; bus.prog_data_in = wd[0];
    bus.prog_valid = 1'b1; bus.mode = 2'b01;
    idx = 0; hs = 0; ns = 0; last = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx >= 3) bus.prog_valid = 1'b0;
        else begin bus.prog_header_in = wh[idx]; bus.prog_data_in = wd[idx]; end
      end
      hs = bus.prog_valid && bus.prog_ready;
      if (bus.clock_slow) seen = 1;
      if (bus.prog_strobe) begin
        if (ns < 3) begin
          check("prog_header", bus.prog_header, wh[ns]);
          check("prog_data", bus.prog_data, wd[ns]);
        end
        if (ns > 0) check("prog_gap", c - last, 2);
        ns++; last = c;
      end
    end
    check("prog_count", ns, 3);
    check("prog_no_tick", seen, 0);
    bus.mode = 2'b00;
    @(negedge clk); @(negedge clk);
    check("prog_exit_ready", bus.prog_ready, 0);
    check("prog_exit_hold", bus.hold, 1);

    // Events: three queued, then one more fills the FIFO and the next is dropped.
    ev_code = 2'b01; ev_mask = 10'b0010100100; rdy_mask = '0;
    do_tick(0);
    check("evt_valid_1", bus.evt_valid, 1);
    check("evt_head_1", bus.evt_id, 2);
    check("evt_ovf_0", bus.overflow, 0);
    ev_code = 2'b10; ev_mask = 10'b0100000010;
    do_tick(0);
    check("evt_ovf_1", bus.overflow, 1);
    check("evt_head_stable", bus.evt_id, 2);
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", bus.evt_valid, 1);
      check("drain_id", bus.evt_id, (k == 0) ? 2 : (k == 1) ? 5 : (k == 2) ? 7 : 1);
      check("drain_code", bus.evt_code, (k == 3) ? 2 : 1);
      @(negedge clk);
    end
    check("drain_empty", bus.evt_valid, 0);
    bus.evt_ready = 1'b0;

    // Full FIFO with push and pop together: nothing lost.
    ev_code = 2'b11; ev_mask = 10'b0000001111;
    do_tick(0);
    ev_code = 2'b01; ev_mask = 10'b0011110000; rdy_mask = 10'b0011110000;
    do_tick(0);
    rdy_mask = '0;
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("swap_valid", bus.evt_valid, 1);
      check("swap_id", bus.evt_id, 4 + k);
      check("swap_code", bus.evt_code, 1);
      @(negedge clk);
    end
    check("swap_empty", bus.evt_valid, 0);
    bus.evt_ready = 1'b0;

    // Refill, load tokens, then reset at processor 5.
    ev_code = 2'b10; ev_mask = 10'b0000000110;
    do_tick(0);
    ev_mask = '0;
    inject(4'd7, 8'd90);
    bus.mode = 2'b11;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (!bus.hold && bus.processor_id == 4'd5) seen = 1;
    end
    check("reach_pid5", seen, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_hold", bus.hold, 1);
    check("mid_rst_clock_slow", bus.clock_slow, 0);
    check("mid_rst_pid", bus.processor_id, 0);
    check("mid_rst_evt_valid", bus.evt_valid, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    check("mid_rst_prog_strobe", bus.prog_strobe, 0);
    check("mid_rst_prog_ready", bus.prog_ready, 0);
    check("mid_rst_prog_header", bus.prog_header, 0);
    check("mid_rst_prog_data", bus.prog_data, 0);
    check("mid_rst_tokens", bus.tokens_in, 0);
    bus.mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk_tok = 1;
    for (int p = 0; p < NP; p++) exp_tok[p] = 8'd0;
    do_tick(4);
    check("post_rst_evt_valid", bus.evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
